serial_link_pwr_seq: RTL and testbench

Per-link power/isolation sequencer for a group of serial link instances. Drives each link's clock-gate enable, link reset and 2-bit AXI isolate request (bit 0 = in, bit 1 = out). Replaces the register-driven clk_ena/reset_n/isolate handling with a timed, handshaked bring-up/tear-down FSM per link. Optionally staggers power-up across links to limit inrush.

---
 rtl/serial_link_pwr_pkg.sv | 42 ++++
 rtl/serial_link_pwr_fsm.sv | 141 ++++++++++++++
 rtl/serial_link_pwr_seq.sv | 69 ++++++
 tb/tb_serial_link_pwr_seq.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_link_pwr_pkg.sv
// Shared types for the serial link power sequencer: per-link state encoding,
// isolate encodings and the state-to-output decode.
package serial_link_pwr_pkg;

  typedef enum logic [2:0] {
    OFF,
    CLK_EN,
    RST_REL,
    UNISO,
    ACTIVE,
    ISO,
    RST_ASS,
    CLK_DIS
  } pwr_state_e;

  // isolate bit 0 = AXI in, bit 1 = AXI out
  localparam logic [1:0] ISO_ALL  = 2'b11;
  localparam logic [1:0] ISO_NONE = 2'b00;

  typedef struct packed {
    logic       clk_ena;
    logic       reset_n;
    logic [1:0] isolate;
  } pwr_out_t;

  function automatic pwr_out_t pwr_decode(pwr_state_e s);
    pwr_out_t o;
    o.clk_ena = !(s inside {OFF, CLK_DIS});
    o.reset_n = s inside {RST_REL, UNISO, ACTIVE, ISO};
    o.isolate = (s inside {UNISO, ACTIVE}) ? ISO_NONE : ISO_ALL;
    return o;
  endfunction

  function automatic int cnt_width(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/serial_link_pwr_fsm.sv
// One link's bring-up/tear-down sequencer with its delay counter and error flag.
// SERIAL_LINK_PWR_SEQ_TIMEOUT_EN adds the isolate handshake timeout.
module serial_link_pwr_fsm
  import serial_link_pwr_pkg::*;
#(
  parameter int unsigned ClkSettleCycles = 4,
  parameter int unsigned ResetCycles     = 8,
  parameter int unsigned TimeoutCycles   = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       power_req,
  input  logic       grant,
  input  logic [1:0] isolated,
  input  logic       err_clr,
  output logic [1:0] isolate,
  output logic       clk_ena,
  output logic       reset_n,
  output logic       active,
  output logic       busy,
  output logic       err,
  output logic       ramping_c,
  output logic       idle_c
);

  localparam int unsigned CntW = cnt_width(ClkSettleCycles, ResetCycles, TimeoutCycles);

  pwr_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            cnt_zero;
  logic            err_set;
  pwr_out_t        out_d;

  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= OFF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter saturates at zero; handshake states only reload it when timeouts exist.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_zero ? cnt_q : cnt_q - CntW'(1);
    err_set = 1'b0;
    unique case (state_q)
      OFF: if (power_req && grant) begin
        state_d = CLK_EN;
        cnt_d   = CntW'(ClkSettleCycles - 1);
      end
      CLK_EN: if (cnt_zero) begin
        state_d = RST_REL;
        cnt_d   = CntW'(ResetCycles - 1);
      end
      RST_REL: if (cnt_zero) begin
        state_d = UNISO;
`ifdef SERIAL_LINK_PWR_SEQ_TIMEOUT_EN
        cnt_d   = CntW'(TimeoutCycles - 1);
`endif
      end
      UNISO: begin
        if (!power_req) begin
          state_d = ISO;
`ifdef SERIAL_LINK_PWR_SEQ_TIMEOUT_EN
          cnt_d   = CntW'(TimeoutCycles - 1);
`endif
        end else if (isolated == ISO_NONE) begin
          state_d = ACTIVE;
        end
`ifdef SERIAL_LINK_PWR_SEQ_TIMEOUT_EN
        else if (cnt_zero) begin
          state_d = ISO;
          cnt_d   = CntW'(TimeoutCycles - 1);
          err_set = 1'b1;
        end
`endif
      end
      ACTIVE: if (!power_req) begin
        state_d = ISO;
`ifdef SERIAL_LINK_PWR_SEQ_TIMEOUT_EN
        cnt_d   = CntW'(TimeoutCycles - 1);
`endif
      end
      ISO: begin
        if (isolated == ISO_ALL) begin
          state_d = RST_ASS;
          cnt_d   = CntW'(ResetCycles - 1);
        end
`ifdef SERIAL_LINK_PWR_SEQ_TIMEOUT_EN
        else if (cnt_zero) begin
          state_d = RST_ASS;
          cnt_d   = CntW'(ResetCycles - 1);
          err_set = 1'b1;
        end
`endif
      end
      RST_ASS: if (cnt_zero) state_d = CLK_DIS;
      CLK_DIS: state_d = OFF;
    endcase
  end

  assign out_d = pwr_decode(state_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      isolate <= ISO_ALL;
      clk_ena <= 1'b0;
      reset_n <= 1'b0;
      active  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      isolate <= out_d.isolate;
      clk_ena <= out_d.clk_ena;
      reset_n <= out_d.reset_n;
      active  <= (state_d == ACTIVE);
      busy    <= !(state_d inside {OFF, ACTIVE});
    end
  end

`ifdef SERIAL_LINK_PWR_SEQ_TIMEOUT_EN
  // Sticky timeout flag; a timeout beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          err <= 1'b0;
    else if (err_set) err <= 1'b1;
    else if (err_clr) err <= 1'b0;
  end
`else
  logic unused_err;
  assign unused_err = ^{err_clr, err_set};
  assign err        = 1'b0;
`endif

  assign ramping_c = (state_q == CLK_EN) || (state_q == RST_REL);
  assign idle_c    = (state_q == OFF);

endmodule

// File: rtl/serial_link_pwr_seq.sv
// Power/isolation sequencer for a group of serial links with optional power-up
// staggering. SERIAL_LINK_PWR_SEQ_TIMEOUT_EN enables isolate handshake timeouts.
module serial_link_pwr_seq
  import serial_link_pwr_pkg::*;
#(
  parameter int unsigned NumLinks        = 2,
  parameter int unsigned ClkSettleCycles = 4,
  parameter int unsigned ResetCycles     = 8,
  parameter int unsigned TimeoutCycles   = 1024,
  parameter int unsigned StaggerOn       = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NumLinks-1:0]   power_req_i,
  input  logic [2*NumLinks-1:0] isolated_i,
  output logic [2*NumLinks-1:0] isolate_o,
  output logic [NumLinks-1:0]   clk_ena_o,
  output logic [NumLinks-1:0]   reset_no,
  output logic [NumLinks-1:0]   active_o,
  output logic [NumLinks-1:0]   busy_o,
  output logic [NumLinks-1:0]   err_o,
  input  logic [NumLinks-1:0]   err_clr_i
);

  logic [NumLinks-1:0] ramping;
  logic [NumLinks-1:0] idle;
  logic [NumLinks-1:0] grant;
  logic                found;

  // Stagger arbiter: lowest requesting idle link, only while nobody is ramping.
  always_comb begin
    grant = '0;
    found = 1'b0;
    if (StaggerOn == 0) begin
      grant = '1;
    end else if (ramping == '0) begin
      for (int i = 0; i < int'(NumLinks); i++) begin
        if (!found && idle[i] && power_req_i[i]) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NumLinks; g++) begin : g_link
    serial_link_pwr_fsm #(
      .ClkSettleCycles(ClkSettleCycles),
      .ResetCycles    (ResetCycles),
      .TimeoutCycles  (TimeoutCycles)
    ) u_fsm (
      .clk      (clk_i),
      .rst      (rst_i),
      .power_req(power_req_i[g]),
      .grant    (grant[g]),
      .isolated (isolated_i[2*g +: 2]),
      .err_clr  (err_clr_i[g]),
      .isolate  (isolate_o[2*g +: 2]),
      .clk_ena  (clk_ena_o[g]),
      .reset_n  (reset_no[g]),
      .active   (active_o[g]),
      .busy     (busy_o[g]),
      .err      (err_o[g]),
      .ramping_c(ramping[g]),
      .idle_c   (idle[g])
    );
  end

endmodule

// File: tb/tb_serial_link_pwr_seq.sv
// Bench for serial_link_pwr_seq: a staggered and an unstaggered instance driven
// by random requests and handshake responders, checked against a deadline model.
module tb_serial_link_pwr_seq;

  localparam int NL = 2;
  localparam int CS = 4;
  localparam int RC = 8;
  localparam int TO = 16;
`ifdef SERIAL_LINK_PWR_SEQ_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  localparam int P_OFF = 0, P_CLK = 1, P_REL = 2, P_UNI = 3;
  localparam int P_ACT = 4, P_ISO = 5, P_ASS = 6, P_DIS = 7;

  logic            clk = 1'b0;
  logic            rst;
  logic [NL-1:0]   req;
  logic [NL-1:0]   clr;
  logic [2*NL-1:0] iso_in [2];
  logic [2*NL-1:0] iso_o  [2];
  logic [NL-1:0]   ck_o   [2];
  logic [NL-1:0]   rn_o   [2];
  logic [NL-1:0]   ac_o   [2];
  logic [NL-1:0]   bs_o   [2];
  logic [NL-1:0]   er_o   [2];

  // model: index 0 = staggered instance, 1 = unstaggered instance
  int ph    [2][NL];
  int dl    [2][NL];
  bit er    [2][NL];
  bit stuck [2][NL];
  int cyc;
  int n_chk;
  int n_fail;

  always #5 clk = ~clk;

  serial_link_pwr_seq #(
    .NumLinks(NL), .ClkSettleCycles(CS), .ResetCycles(RC),
    .TimeoutCycles(TO), .StaggerOn(1)
  ) u_dut_stag (
    .clk_i(clk), .rst_i(rst), .power_req_i(req), .isolated_i(iso_in[0]),
    .isolate_o(iso_o[0]), .clk_ena_o(ck_o[0]), .reset_no(rn_o[0]),
    .active_o(ac_o[0]), .busy_o(bs_o[0]), .err_o(er_o[0]), .err_clr_i(clr)
  );

  serial_link_pwr_seq #(
    .NumLinks(NL), .ClkSettleCycles(CS), .ResetCycles(RC),
    .TimeoutCycles(TO), .StaggerOn(0)
  ) u_dut_free (
    .clk_i(clk), .rst_i(rst), .power_req_i(req), .isolated_i(iso_in[1]),
    .isolate_o(iso_o[1]), .clk_ena_o(ck_o[1]), .reset_no(rn_o[1]),
    .active_o(ac_o[1]), .busy_o(bs_o[1]), .err_o(er_o[1]), .err_clr_i(clr)
  );

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // {clk_ena, reset_n, isolate[1:0]} for each phase
  function automatic logic [3:0] exp_out(int p);
    case (p)
      P_CLK:   return 4'b1011;
      P_REL:   return 4'b1111;
      P_UNI:   return 4'b1100;
      P_ACT:   return 4'b1100;
      P_ISO:   return 4'b1111;
      P_ASS:   return 4'b1011;
      default: return 4'b0011;
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int l = 0; l < NL; l++) begin
        ph[d][l] = P_OFF;
        dl[d][l] = 0;
        er[d][l] = 1'b0;
      end
  endtask

  task automatic go(int d, int l, int p, int len);
    ph[d][l] = p;
    dl[d][l] = cyc + len;
  endtask

  task automatic model_step(int d);
    bit         ramp, g, set, due;
    int         gl;
    logic [1:0] iv;
    ramp = 1'b0;
    gl   = -1;
    for (int l = 0; l < NL; l++)
      if (ph[d][l] == P_CLK || ph[d][l] == P_REL) ramp = 1'b1;
    for (int l = 0; l < NL; l++)
      if (gl < 0 && ph[d][l] == P_OFF && req[l]) gl = l;
    for (int l = 0; l < NL; l++) begin
      iv  = iso_in[d][2*l +: 2];
      g   = (d == 1) || (!ramp && gl == l);
      due = (cyc == dl[d][l]);
      set = 1'b0;
      case (ph[d][l])
        P_OFF: if (req[l] && g) go(d, l, P_CLK, CS);
        P_CLK: if (due) go(d, l, P_REL, RC);
        P_REL: if (due) go(d, l, P_UNI, TO);
        P_UNI: begin
          if (!req[l]) go(d, l, P_ISO, TO);
          else if (iv == 2'b00) ph[d][l] = P_ACT;
          else if (TMO && due) begin go(d, l, P_ISO, TO); set = 1'b1; end
        end
        P_ACT: if (!req[l]) go(d, l, P_ISO, TO);
        P_ISO: begin
          if (iv == 2'b11) go(d, l, P_ASS, RC);
          else if (TMO && due) begin go(d, l, P_ASS, RC); set = 1'b1; end
        end
        P_ASS: if (due) ph[d][l] = P_DIS;
        default: ph[d][l] = P_OFF;
      endcase
      if (TMO) begin
        if (set) er[d][l] = 1'b1;
        else if (clr[l]) er[d][l] = 1'b0;
      end
    end
  endtask

  task automatic check_dut(int d);
    logic [2*NL-1:0] ei;
    logic [NL-1:0]   ec, en, ea, eb, ee;
    logic [3:0]      o;
    for (int l = 0; l < NL; l++) begin
      o            = exp_out(ph[d][l]);
      ei[2*l +: 2] = o[1:0];
      ec[l]        = o[3];
      en[l]        = o[2];
      ea[l]        = (ph[d][l] == P_ACT);
      eb[l]        = !(ph[d][l] == P_OFF || ph[d][l] == P_ACT);
      ee[l]        = er[d][l];
    end
    check_eq($sformatf("d%0d isolate_o", d), 32'(iso_o[d]), 32'(ei));
    check_eq($sformatf("d%0d clk_ena_o", d), 32'(ck_o[d]), 32'(ec));
    check_eq($sformatf("d%0d reset_no", d), 32'(rn_o[d]), 32'(en));
    check_eq($sformatf("d%0d active_o", d), 32'(ac_o[d]), 32'(ea));
    check_eq($sformatf("d%0d busy_o", d), 32'(bs_o[d]), 32'(eb));
    check_eq($sformatf("d%0d err_o", d), 32'(er_o[d]), 32'(ee));
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step(0);
    model_step(1);
    #1;
    check_dut(0);
    check_dut(1);
  endtask

  // isolate blocks follow the requested isolation after a random delay
  task automatic respond(int pct);
    logic [1:0] want;
    for (int d = 0; d < 2; d++)
      for (int l = 0; l < NL; l++) begin
        want = exp_out(ph[d][l]) & 4'b0011;
        if (!stuck[d][l] && iso_in[d][2*l +: 2] != want && int'($urandom_range(0, 99)) < pct)
          iso_in[d][2*l +: 2] = want;
      end
  endtask

  task automatic mid_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check_dut(0);
    check_dut(1);
    @(posedge clk);
    #1;
    check_dut(0);
    check_dut(1);
    rst = 1'b0;
  endtask

  function automatic bit all_off();
    for (int d = 0; d < 2; d++)
      for (int l = 0; l < NL; l++)
        if (ph[d][l] != P_OFF) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    int t_act;
    bit pend;
    int rise [2][NL];
    n_chk  = 0;
    n_fail = 0;
    cyc    = 0;
    rst    = 1'b1;
    req    = '0;
    clr    = '0;
    iso_in[0] = '1;
    iso_in[1] = '1;
    for (int d = 0; d < 2; d++)
      for (int l = 0; l < NL; l++) stuck[d][l] = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_dut(0);
    check_dut(1);
    rst = 1'b0;

    // power-on latency with a prompt isolate acknowledgement
    req   = 2'b01;
    pend  = 1'b0;
    t_act = -1;
    for (int t = 1; t <= 40 && t_act < 0; t++) begin
      tick();
      if (ac_o[0][0]) t_act = t;
      if (pend) begin
        iso_in[0][1:0] = 2'b00;
        iso_in[1][1:0] = 2'b00;
      end
      pend = (iso_o[0][1:0] == 2'b00);
    end
    check_eq("on_latency", 32'(t_act), 32'(CS + RC + 3));

    // tear-down back to OFF
    req = '0;
    for (int t = 0; t < 60 && !all_off(); t++) begin
      respond(100);
      tick();
    end
    check_eq("teardown_idle", 32'(all_off()), 32'd1);

    // simultaneous requests: staggered vs unstaggered clock-enable rise
    for (int d = 0; d < 2; d++)
      for (int l = 0; l < NL; l++) rise[d][l] = -1;
    req = 2'b11;
    for (int t = 1; t <= 40; t++) begin
      tick();
      for (int d = 0; d < 2; d++)
        for (int l = 0; l < NL; l++)
          if (rise[d][l] < 0 && ck_o[d][l]) rise[d][l] = t;
      respond(100);
    end
    check_eq("stag_first", 32'(rise[0][0]), 32'd1);
    check_eq("stag_gap", 32'(rise[0][1] - rise[0][0]), 32'(CS + RC + 1));
    check_eq("free_gap", 32'(rise[1][1] - rise[1][0]), 32'd0);

    // randomized traffic with stuck handshakes, clears and async resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) mid_reset();
      for (int l = 0; l < NL; l++) begin
        if ($urandom_range(0, 24) == 0) req[l] = ~req[l];
        clr[l] = ($urandom_range(0, 19) == 0);
        for (int d = 0; d < 2; d++)
          if ($urandom_range(0, 149) == 0) stuck[d][l] = ~stuck[d][l];
      end
      respond(40);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
